// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: command codes, FSM states, round constants and
// the GF(2^8) / ShiftRows / MixColumns helpers used by the iterative engine.
package aes_pkg;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NBYTES     = 16;
  localparam int unsigned BLK_W      = BYTE_W * NBYTES;
  localparam logic [3:0]  LAST_ROUND = 4'd10;

  // Element 0 is bits [127:120], i.e. FIPS-197 input byte 0.
  typedef logic [0:NBYTES-1][BYTE_W-1:0] blk_t;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_SP   = 2'b01,
    CMD_SK   = 2'b10,
    CMD_ST   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic logic [7:0] rcon(input logic [3:0] round);
    case (round)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic blk_t shift_rows(input blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4'(4 * c + r)] = s[4'(4 * ((c + r) % 4) + r)];
      end
    end
    return o;
  endfunction

  function automatic blk_t mix_columns(input blk_t s);
    blk_t        o;
    logic [31:0] m;
    for (int c = 0; c < 4; c++) begin
      m = mix_col({s[4'(4 * c)], s[4'(4 * c + 1)], s[4'(4 * c + 2)], s[4'(4 * c + 3)]});
      o[4'(4 * c)]     = m[31:24];
      o[4'(4 * c + 1)] = m[23:16];
      o[4'(4 * c + 2)] = m[15:8];
      o[4'(4 * c + 3)] = m[7:0];
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse (as a^254) followed by the
// FIPS-197 affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] w_inv;

  assign w_inv  = gf_inv(i_byte);
  assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_engine.sv
// Iterative AES-128 encryption core: byte-serial plaintext/key load, one
// cipher round per clock with the key schedule expanded on the fly.
module aes_engine
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_,
  input  logic [7:0]       din,
  input  logic [1:0]       cmd,
  output logic             interface_ready,
  output logic             engine_done,
  output logic [BLK_W-1:0] ciphertext
);
  state_e      r_state;
  cmd_e        r_prev_cmd;
  blk_t        r_pt;
  blk_t        r_key;
  blk_t        r_st;
  blk_t        r_ct;
  logic [127:0] r_rk;
  logic [3:0]  r_idx;
  logic [3:0]  r_round;
  logic        r_ready;
  logic        r_done;

  cmd_e        w_cmd;
  logic        w_cmd_chg;
  logic        w_load;
  logic [3:0]  w_idx;
  blk_t        w_sub;
  blk_t        w_sr;
  blk_t        w_mc;
  blk_t        w_rnd;
  logic [31:0] w_rot;
  logic [31:0] w_ksub;
  logic [31:0] w_k0, w_k1, w_k2, w_k3;
  logic [127:0] w_nk;

  // A change of command restarts the byte index so each stream begins at byte 0.
  assign w_cmd     = cmd_e'(cmd);
  assign w_cmd_chg = (w_cmd != r_prev_cmd);
  assign w_load    = ((w_cmd == CMD_SP) || (w_cmd == CMD_SK)) && (r_state != BUSY);
  assign w_idx     = w_cmd_chg ? 4'd0 : r_idx;

  for (genvar i = 0; i < NBYTES; i++) begin : g_state_sbox
    aes_sbox u_sbox (.i_byte(r_st[i]), .o_byte(w_sub[i]));
  end

  assign w_rot = {r_rk[23:0], r_rk[31:24]};
  for (genvar k = 0; k < 4; k++) begin : g_key_sbox
    aes_sbox u_sbox (.i_byte(w_rot[31-8*k -: 8]), .o_byte(w_ksub[31-8*k -: 8]));
  end

  assign w_k0 = r_rk[127:96] ^ w_ksub ^ {rcon(r_round), 24'h000000};
  assign w_k1 = r_rk[95:64] ^ w_k0;
  assign w_k2 = r_rk[63:32] ^ w_k1;
  assign w_k3 = r_rk[31:0]  ^ w_k2;
  assign w_nk = {w_k0, w_k1, w_k2, w_k3};

  assign w_sr  = shift_rows(w_sub);
  assign w_mc  = mix_columns(w_sr);
  assign w_rnd = ((r_round == LAST_ROUND) ? w_sr : w_mc) ^ w_nk;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= IDLE;
      r_prev_cmd <= CMD_IDLE;
      r_pt       <= '0;
      r_key      <= '0;
      r_st       <= '0;
      r_ct       <= '0;
      r_rk       <= '0;
      r_idx      <= 4'd0;
      r_round    <= 4'd0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_prev_cmd <= w_cmd;
      if (w_load) begin
        if (w_cmd == CMD_SP) r_pt[w_idx]  <= din;
        else                 r_key[w_idx] <= din;
        r_idx <= w_idx + 4'd1;
      end else if ((w_cmd == CMD_IDLE) || w_cmd_chg) begin
        r_idx <= 4'd0;
      end

      case (r_state)
        IDLE: begin
          if (w_cmd == CMD_ST) begin
            r_st    <= r_pt ^ r_key;
            r_rk    <= r_key;
            r_round <= 4'd1;
            r_ready <= 1'b0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_st <= w_rnd;
          r_rk <= w_nk;
          if (r_round == LAST_ROUND) begin
            r_ct    <= w_rnd;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= DONE;
          end else begin
            r_round <= r_round + 4'd1;
          end
        end
        DONE: begin
          // Holding Start keeps the result; anything else returns to IDLE.
          if (w_cmd != CMD_ST) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign interface_ready = r_ready;
  assign engine_done     = r_done;
  assign ciphertext      = r_ct;
endmodule

// File: tb/tb_aes_engine.sv
// Directed bench for aes_engine: FIPS-197 vectors, index/handshake corners and
// a byte-wise reference AES for vectors without published answers.
module tb_aes_engine;
  logic         clk;
  logic         rst_;
  logic [7:0]   din;
  logic [1:0]   cmd;
  logic         interface_ready;
  logic         engine_done;
  logic [127:0] ciphertext;

  int n_checks;
  int n_errors;

  logic [7:0] sbox_t [256];
  logic [7:0] rcon_t [10];

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] A_PT   = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] A_KEY  = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] S_PT   = 128'h00041214120412000c00131108231919;
  localparam logic [127:0] S_KEY  = 128'h2475a2b33475568831e2120013aa5487;

  aes_engine dut (
    .clk             (clk),
    .rst_            (rst_),
    .din             (din),
    .cmd             (cmd),
    .interface_ready (interface_ready),
    .engine_done     (engine_done),
    .ciphertext      (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box by brute-force inverse search, Rcon by repeated doubling.
  task automatic build_tables();
    logic [7:0] inv, rc;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    rc = 8'h01;
    for (int i = 0; i < 10; i++) begin
      rcon_t[i] = rc;
      rc = gmul(rc, 8'h02);
    end
  endtask

  task automatic aes_ref(input logic [127:0] pt, input logic [127:0] key, output logic [127:0] ct);
    logic [7:0] w   [176];
    logic [7:0] st  [16];
    logic [7:0] tmp [16];
    logic [7:0] t   [4];
    logic [7:0] t0, a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) begin
      w[i]  = 8'(key >> (8 * (15 - i)));
      st[i] = 8'(pt >> (8 * (15 - i))) ^ w[i];
    end
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[4 * (i - 1) + j];
      if (i % 4 == 0) begin
        t0   = t[0];
        t[0] = sbox_t[t[1]] ^ rcon_t[i / 4 - 1];
        t[1] = sbox_t[t[2]];
        t[2] = sbox_t[t[3]];
        t[3] = sbox_t[t0];
      end
      for (int j = 0; j < 4; j++) w[4 * i + j] = w[4 * (i - 4) + j] ^ t[j];
    end
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) st[i] = sbox_t[st[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          tmp[4 * c + row] = st[4 * ((c + row) % 4) + row];
      for (int c = 0; c < 4; c++) begin
        a0 = tmp[4 * c]; a1 = tmp[4 * c + 1]; a2 = tmp[4 * c + 2]; a3 = tmp[4 * c + 3];
        if (r < 10) begin
          st[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          st[4 * c] = a0; st[4 * c + 1] = a1; st[4 * c + 2] = a2; st[4 * c + 3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16 * r + i];
    end
    ct = '0;
    for (int i = 0; i < 16; i++) ct = {ct[119:0], st[i]};
  endtask

  task automatic load_blk(input logic [1:0] c, input logic [127:0] v);
    logic [127:0] s;
    s = v;
    for (int i = 0; i < 16; i++) begin
      cmd = c;
      din = s[127:120];
      s   = s << 8;
      cycle();
    end
  endtask

  // Samples Start at E0, then counts edges until engine_done (bounded).
  task automatic start_run(input string tag, output int lat);
    cmd = 2'b11;
    cycle();
    chk({tag, "_ready_low"}, 128'(interface_ready), 128'(1'b0));
    lat = 0;
    while (!engine_done && lat < 30) begin
      cycle();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [127:0] exp_ct;
    logic [127:0] pt_mod;
    n_checks = 0;
    n_errors = 0;
    rst_ = 1'b0;
    cmd  = 2'b00;
    din  = 8'h00;
    build_tables();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 128'(interface_ready), 128'(1'b1));
    chk("rst_done",  128'(engine_done),     128'(1'b0));
    chk("rst_ct",    ciphertext,            128'h0);
    rst_ = 1'b1;
    cycle();

    // App. C.1, key loaded straight after plaintext with no Idle between.
    load_blk(2'b01, C1_PT);
    load_blk(2'b10, C1_KEY);
    start_run("c1", lat);
    chk("c1_latency", 128'(lat), 128'(10));
    chk("c1_ct",      ciphertext, C1_CT);
    chk("c1_ready",   128'(interface_ready), 128'(1'b1));

    // Holding Start in DONE must not restart.
    repeat (3) cycle();
    chk("hold_done",  128'(engine_done), 128'(1'b1));
    chk("hold_ct",    ciphertext, C1_CT);
    cmd = 2'b00;
    cycle();
    chk("idle_done_fall", 128'(engine_done), 128'(1'b0));
    chk("idle_ready",     128'(interface_ready), 128'(1'b1));
    chk("idle_ct_kept",   ciphertext, C1_CT);

    // App. B with an Idle gap between plaintext and key.
    load_blk(2'b01, B_PT);
    cmd = 2'b00;
    cycle();
    load_blk(2'b10, B_KEY);
    start_run("b", lat);
    chk("b_latency", 128'(lat), 128'(10));
    chk("b_ct",      ciphertext, B_CT);

    // Load straight out of DONE; 17th plaintext byte overwrites byte 0.
    load_blk(2'b01, A_PT);
    chk("done_exit_on_load", 128'(engine_done), 128'(1'b0));
    cmd = 2'b01;
    din = 8'ha5;
    cycle();
    load_blk(2'b10, A_KEY);
    pt_mod = {8'ha5, A_PT[119:0]};
    aes_ref(pt_mod, A_KEY, exp_ct);
    start_run("idx", lat);
    chk("idx_ct", ciphertext, exp_ct);

    // Loads during BUSY must not disturb the stored plaintext or key.
    cmd = 2'b00;
    cycle();
    cmd = 2'b11;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cmd = 2'b01;
      din = 8'($urandom);
      cycle();
    end
    for (int i = 0; i < 2; i++) begin
      cmd = 2'b10;
      din = 8'($urandom);
      cycle();
    end
    cmd = 2'b00;
    lat = 7;
    while (!engine_done && lat < 30) begin
      cycle();
      lat++;
    end
    chk("busy_load_latency", 128'(lat), 128'(10));
    chk("busy_load_ct",      ciphertext, exp_ct);
    cycle();
    chk("busy_load_done_fall", 128'(engine_done), 128'(1'b0));

    // Byte-stream vector checked against the reference model.
    load_blk(2'b01, S_PT);
    load_blk(2'b10, S_KEY);
    aes_ref(S_PT, S_KEY, exp_ct);
    start_run("bs", lat);
    chk("bs_latency", 128'(lat), 128'(10));
    chk("bs_ct",      ciphertext, exp_ct);

    // Reset in the middle of BUSY aborts the run asynchronously.
    cmd = 2'b00;
    cycle();
    cmd = 2'b11;
    cycle();
    repeat (4) cycle();
    #2;
    rst_ = 1'b0;
    #1;
    chk("mid_rst_done",  128'(engine_done), 128'(1'b0));
    chk("mid_rst_ready", 128'(interface_ready), 128'(1'b1));
    chk("mid_rst_ct",    ciphertext, 128'h0);
    cmd = 2'b00;
    cycle();
    rst_ = 1'b1;
    repeat (12) cycle();
    chk("post_rst_no_done", 128'(engine_done), 128'(1'b0));

    load_blk(2'b01, C1_PT);
    load_blk(2'b10, C1_KEY);
    start_run("post_rst", lat);
    chk("post_rst_latency", 128'(lat), 128'(10));
    chk("post_rst_ct",      ciphertext, C1_CT);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/aes_engine.md
# aes_engine

Iterative AES-128 encryption core with a byte-serial load interface. A host streams a 16-byte plaintext and a 16-byte key over an 8-bit bus under a 2-bit command, then issues Start. The core runs the FIPS-197 cipher one round per clock, flags completion, and presents the 128-bit ciphertext. It sits behind the host command decoder as a standalone crypto leaf block.

## Interface
- No parameters. AES-128 only; block and key are 128 bits.
- `clk` in 1: single clock, all state on rising edge.
- `rst_` in 1: asynchronous, active-low reset.
- `din` in 8: load byte, sampled on every rising edge while `cmd` is 01 or 10.
- `cmd` in 2: 00 Idle, 01 Set plaintext, 10 Set key, 11 Start.
- `interface_ready` out 1: high when loads and Start are accepted (states IDLE, DONE).
- `engine_done` out 1: high while `ciphertext` holds a valid result (state DONE).
- `ciphertext` out 128: result; byte 0 (first plaintext byte position) is bits [127:120].

## Operation
- Registers: `pt_reg`[127:0], `key_reg`[127:0], byte index `idx`[3:0], round state, round key, round counter 0..10.
- Load:
  - Set plaintext (01): `din` is written to byte `idx` of `pt_reg`. Byte 0 is bits [127:120], in FIPS-197 input order.
  - Set key (10): `din` is written to byte `idx` of `key_reg` in the same way.
  - `idx` increments on each load and wraps 15→0, so a 17th byte overwrites byte 0.
  - `idx` clears to 0 when `cmd` differs from its value at the previous edge, or when `cmd` is Idle.
  - Loads are ignored in BUSY.
- FSM states:
  - IDLE: 01/10 load. 11 → BUSY and captures state = `pt_reg` ^ `key_reg` (round 0). 00 holds.
  - BUSY: one round per edge, round counter 1..10. Rounds 1–9 are SubBytes, ShiftRows, MixColumns, AddRoundKey. Round 10 omits MixColumns. After round 10, write `ciphertext` and go → DONE. `cmd` is ignored in BUSY.
  - DONE: `cmd` 11 holds DONE, so there is no auto-restart. 00 → IDLE. 01/10 perform the load and go → IDLE. `ciphertext` is retained until the next completion or reset.
- Key schedule is computed on the fly:
  - next word0 = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r].
  - Rcon sequence is 01,02,04,08,10,20,40,80,1B,36.
- If Start arrives with partially loaded registers, the core encrypts the current register contents. This is not an error.

## Timing
- Reset values: `interface_ready`=1, `engine_done`=0, `ciphertext`=0, `pt_reg`/`key_reg`/`idx`=0, FSM=IDLE.
- Reset asserted mid-encryption aborts immediately; no `engine_done` follows.
- Load: one byte per edge, no back-pressure. 16 consecutive edges load a full block.
- Start latency:
  - Edge E0 samples 11 in IDLE; `interface_ready` falls after E0.
  - Rounds 1..10 run on edges E1..E10.
  - `engine_done` rises and `ciphertext` becomes valid after E10, which is 10 cycles after Start is sampled.
  - `interface_ready` rises together with `engine_done`.
- `engine_done` is a level. It falls on the first edge where `cmd` is not 11.
- Back-to-back block: after a result, `cmd` must leave 11 for at least one edge before a new Start.

## Structure
- Shared package `aes_pkg` holds:
  - command encodings CMD_IDLE/CMD_SP/CMD_SK/CMD_ST;
  - FSM state enum IDLE/BUSY/DONE;
  - Rcon constants;
  - xtime/MixColumns helper functions.
- Sub-module `aes_sbox`: combinational 8→8 forward S-box, either GF(2^8) inverse plus affine transform or a 256-entry ROM.
  - Instantiated 16× for the state and 4× for the key schedule.

## Test plan
- Reset:
  - Assert `rst_`=0 mid-BUSY → `engine_done`=0, `interface_ready`=1, `ciphertext`=0 asynchronously.
  - After release, a fresh Start produces the correct result.
- FIPS-197 App. C.1:
  - Plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, then Start.
  - Require `ciphertext`=69c4e0d86a7b0430d8cdb78070b4c55a and `engine_done` high 10 cycles after Start is sampled.
- FIPS-197 App. B:
  - Plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Require `ciphertext`=3925841d02dc09fbdc118597196a0b32.
- Index behaviour:
  - Load 17 plaintext bytes; the 17th replaces byte 0.
  - Switch directly from 01 to 10 with no Idle between; the key starts at byte 0.
  - Compare the result against a reference model.
- Handshake:
  - Hold 11 after done → no second run, `ciphertext` stable, `engine_done` stays 1.
  - Drive 00 → `engine_done` falls on the next edge.
  - Loads issued during BUSY leave `pt_reg` unchanged.
- Byte-stream load with plaintext 00 04 12 14 12 04 12 00 0C 00 13 11 08 23 19 19 and key 24 75 A2 B3 34 75 56 88 31 E2 12 00 13 AA 54 87, then Start:
  - `ciphertext` must equal the reference-model AES-128 output.
  - `engine_done` must rise after exactly 10 cycles.
